// File: rtl/mem_sync.sv
// mem_sync: synchronous word memory with wait states, ready/err handshake, byte-lane writes; ports clk, rst, i_rd, i_wr, i_addr, i_byte_en, io_data, o_ready, o_err
module mem_sync #(
  parameter int    DATA_WIDTH  = 32,
  parameter int    ADDR_WIDTH  = 16,
  parameter int    DEPTH       = 65536,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_rd,
  input  logic                    i_wr,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH/8-1:0] i_byte_en,
  inout  logic [DATA_WIDTH-1:0]   io_data,
  output logic                    o_ready,
  output logic                    o_err
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIM = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] CNT0 = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [NB-1:0]         r_be;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic                  r_wr, r_perr, r_oe, r_ready, r_err;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  w_idle, w_req, w_perr, w_wr, w_ok, w_enter, w_commit;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [NB-1:0]         w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  assign w_idle   = r_state == IDLE;
  assign w_req    = w_idle & (i_rd | i_wr);
  assign w_addr   = w_idle ? i_addr : r_addr;
  assign w_be     = w_idle ? i_byte_en : r_be;
  assign w_wdata  = w_idle ? io_data : r_wdata;
  assign w_wr     = w_idle ? i_wr : r_wr;
  assign w_perr   = w_idle ? i_rd & i_wr : r_perr;
  assign w_ok     = {1'b0, w_addr} < LIM;
  assign w_enter  = (w_req & ((i_rd & i_wr) | (WAIT_STATES == 0))) | (r_state == BUSY && r_cnt == 4'd0);
  assign w_commit = w_enter & w_wr & ~w_perr & w_ok;
  assign io_data  = r_oe ? r_rdata : 'z;
  assign o_ready  = r_ready;
  assign o_err    = r_err;
  always_ff @(posedge clk)
    if (!rst && w_commit)
      for (int i = 0; i < NB; i++)
        if (w_be[i]) r_mem[w_addr[AW-1:0]][8*i +: 8] <= w_wdata[8*i +: 8];
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_err   <= 1'b0;
      r_oe    <= 1'b0;
      r_cnt   <= CNT0;
    end else begin
      r_ready <= w_enter;
      r_err   <= w_enter & (w_perr | ~w_ok);
      r_oe    <= w_enter & ~w_wr & ~w_perr;
      r_rdata <= w_ok ? r_mem[w_addr[AW-1:0]] : '0;
      r_cnt   <= r_state == BUSY ? r_cnt - 4'd1 : CNT0;
      r_state <= w_enter ? DONE : w_req ? BUSY : r_state == DONE ? IDLE : r_state;
      if (w_req) begin
        r_addr  <= i_addr;
        r_be    <= i_byte_en;
        r_wdata <= io_data;
        r_wr    <= i_wr;
        r_perr  <= i_rd & i_wr;
      end
    end
endmodule
